// File: rtl/leds_pkg.sv
// Shared constants, types and helpers for the LED PWM driver.
// The board defaults live here so the top and the per-channel fader agree.
package leds_pkg;

    localparam int PWM_BITS_DEF   = 8;
    localparam int LED_COUNT      = 4;
    localparam bit ACTIVE_LOW_DEF = 1'b0;

    typedef logic [PWM_BITS_DEF-1:0] level_t;

    // Direction a fader level moves on a ramp step.
    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } ramp_dir_t;

    // Counter width for a modulo-n counter; at least one bit so n=1 still elaborates.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/leds_fader.sv
// One LED channel: samples its on/off request into a target, ramps the
// brightness level toward it one unit per step, and compares against pwm_cnt.
module leds_fader
    import leds_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample,
    input  logic                step,
    input  logic                req,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                on,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] ZERO = '0;

    logic [PWM_BITS-1:0] target_reg;
    logic [PWM_BITS-1:0] target_next;
    logic [PWM_BITS-1:0] level_reg;
    logic [PWM_BITS-1:0] level_next;
    logic                on_reg;
    logic                busy_reg;
    ramp_dir_t           dir;

    always_comb begin
        target_next = target_reg;
        if (sample) begin
            target_next = req ? MAX : ZERO;
        end
    end

    // The step looks at the freshly sampled target, so a coinciding sample
    // and step never waste a step moving toward a stale target.
    always_comb begin
        dir = DIR_HOLD;
        if (step) begin
            if (level_reg < target_next) begin
                dir = DIR_UP;
            end else if (level_reg > target_next) begin
                dir = DIR_DOWN;
            end
        end
    end

    always_comb begin
        level_next = level_reg;
        case (dir)
            DIR_UP:   level_next = level_reg + 1'b1;
            DIR_DOWN: level_next = level_reg - 1'b1;
            default:  level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg <= ZERO;
            level_reg  <= ZERO;
            on_reg     <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            target_reg <= target_next;
            level_reg  <= level_next;
            // Full level is forced on so the last counter value leaves no dark tick.
            on_reg     <= (level_reg == MAX) || (pwm_cnt < level_reg);
            busy_reg   <= (level_reg != target_reg);
        end
    end

    assign on   = on_reg;
    assign busy = busy_reg;

endmodule

// File: rtl/leds_driver.sv
// Four-channel LED PWM driver with soft linear on/off ramps.
// Shared timebase (prescaler, PWM counter, ramp counter) feeds one fader per LED.
module leds_driver
    import leds_pkg::*;
#(
    parameter int PRESCALE     = 16,
    parameter int PWM_BITS     = PWM_BITS_DEF,
    parameter int RAMP_PERIODS = 2,
    parameter bit ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_en,
    input  logic                 ctrl_led0,
    input  logic                 ctrl_led1,
    input  logic                 ctrl_led2,
    input  logic                 ctrl_led3,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 busy
);

    localparam int PRE_W  = cnt_width(PRESCALE);
    localparam int RAMP_W = cnt_width(RAMP_PERIODS);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] MAX       = '1;

    logic [PRE_W-1:0]     prescaler_reg;
    logic [PWM_BITS-1:0]  pwm_cnt_reg;
    logic [RAMP_W-1:0]    ramp_cnt_reg;
    logic                 tick;
    logic                 period_start;
    logic                 step;
    logic [LED_COUNT-1:0] req;
    logic [LED_COUNT-1:0] on_vec;
    logic [LED_COUNT-1:0] busy_vec;

    assign tick         = (prescaler_reg == PRE_LAST);
    assign period_start = tick && (pwm_cnt_reg == MAX);
    assign step         = period_start && (ramp_cnt_reg == RAMP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg <= '0;
            pwm_cnt_reg   <= '0;
            ramp_cnt_reg  <= '0;
        end else begin
            if (tick) begin
                prescaler_reg <= '0;
                pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
            end else begin
                prescaler_reg <= prescaler_reg + 1'b1;
            end
            if (period_start) begin
                ramp_cnt_reg <= step ? '0 : ramp_cnt_reg + 1'b1;
            end
        end
    end

    // A dropped global enable reads as "off" for every channel.
    assign req = {ctrl_led3, ctrl_led2, ctrl_led1, ctrl_led0} & {LED_COUNT{ctrl_en}};

    generate
        for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_fader
            leds_fader #(
                .PWM_BITS (PWM_BITS)
            ) u_fader (
                .clk     (clk),
                .rst     (rst),
                .sample  (period_start),
                .step    (step),
                .req     (req[gi]),
                .pwm_cnt (pwm_cnt_reg),
                .on      (on_vec[gi]),
                .busy    (busy_vec[gi])
            );
        end
    endgenerate

    // Pure inversion of registered bits keeps the pins glitch-free.
    assign led_out = on_vec ^ {LED_COUNT{ACTIVE_LOW}};
    assign busy    = |busy_vec;

endmodule
